phase_seq: RTL and testbench

PHASE_SEQ -- requirements
Module: phase_seq

---
 rtl/simple_pkg.sv | 18 +
 rtl/phase_ring.sv | 44 ++++
 rtl/phase_seq.sv | 137 +++++++++++++
 tb/tb_phase_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_pkg.sv
// ----------------------------------------------------------------------------
// simple_pkg
// Shared definitions for the phase sequencer: controller state encoding and
// default geometry constants.
// ----------------------------------------------------------------------------
package simple_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam int DEF_NPHASE = 5;
    localparam int DEF_PC_W   = 16;

endpackage

// File: rtl/phase_ring.sv
// ----------------------------------------------------------------------------
// phase_ring
// One-hot phase rotator. Bit k moves to bit k+1 each cycle, and the top bit
// wraps to bit 0.
// Priority: clear > start > hold > rotate.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (ring all-zero)
//   start  load phase bit 0
//   hold   freeze the current phase
//   clear  force all-zero
//   phase  one-hot phase vector (all-zero when idle)
// ----------------------------------------------------------------------------
module phase_ring
    import simple_pkg::*;
#(
    parameter int NPHASE = DEF_NPHASE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hold,
    input  logic              clear,
    output logic [NPHASE-1:0] phase
);

    localparam logic [NPHASE-1:0] FIRST = {{(NPHASE-1){1'b0}}, 1'b1};

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (clear) begin
            phase <= '0;
        end else if (start) begin
            phase <= FIRST;
        end else if (!hold) begin
            phase <= {phase[NPHASE-2:0], phase[NPHASE-1]};
        end
    end

endmodule

// File: rtl/phase_seq.sv
// ----------------------------------------------------------------------------
// phase_seq
// Instruction phase sequencer. It runs an IDLE/RUN/STEP/HALT controller, drives
// a one-hot phase ring, and owns the program counter and the retired-
// instruction counter.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   exec           run/pause pulse (start in IDLE, pause request in RUN)
//   step_mode      sampled on exec in IDLE: 1 = single instruction
//   halt_req       sampled only at instruction end
//   mem_wait       stretches phase MEM_PHASE while high
//   branch_taken   at instruction end, load branch_target instead of pc+1
//   branch_target  branch destination
//   phase          one-hot phase enables, all-zero outside RUN/STEP
//   pc             current instruction address
//   pc_plus_one    pc+1 (combinational, wraps)
//   running        state is RUN or STEP
//   halted         state is HALT
//   instr_count    retired instructions
//
// Configuration
//   PHASE_SEQ_ICOUNT_EN  when defined, instr_count is a live 32-bit counter;
//                        otherwise it is tied to zero and has no flops.
// ----------------------------------------------------------------------------
module phase_seq
    import simple_pkg::*;
#(
    parameter int NPHASE    = DEF_NPHASE,
    parameter int PC_W      = DEF_PC_W,
    parameter int MEM_PHASE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exec,
    input  logic              step_mode,
    input  logic              halt_req,
    input  logic              mem_wait,
    input  logic              branch_taken,
    input  logic [PC_W-1:0]   branch_target,
    output logic [NPHASE-1:0] phase,
    output logic [PC_W-1:0]   pc,
    output logic [PC_W-1:0]   pc_plus_one,
    output logic              running,
    output logic              halted,
    output logic [31:0]       instr_count
);

    state_t state, state_nxt;
    logic   pause_req, pause_nxt;
    logic   ring_start, ring_clear;
    logic   stall, end_instr;

    // A stalled final phase is not yet the end of the instruction. The end
    // only fires on the cycle the last phase actually retires.
    assign stall     = mem_wait && phase[MEM_PHASE];
    assign end_instr = phase[NPHASE-1] && !stall;

    assign pc_plus_one = pc + 1'b1;
    assign running     = (state == ST_RUN) || (state == ST_STEP);
    assign halted      = (state == ST_HALT);

    phase_ring #(.NPHASE(NPHASE)) u_ring (
        .clk   (clk),
        .rst_n (rst_n),
        .start (ring_start),
        .hold  (stall),
        .clear (ring_clear),
        .phase (phase)
    );

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        pause_nxt  = pause_req;
        ring_start = 1'b0;
        ring_clear = 1'b0;
        case (state)
            ST_IDLE: begin
                if (exec) begin
                    ring_start = 1'b1;
                    state_nxt  = step_mode ? ST_STEP : ST_RUN;
                end
            end
            ST_RUN: begin
                if (exec) pause_nxt = 1'b1;
                if (end_instr) begin
                    // Halt wins over a pending pause. An exec arriving on
                    // the final cycle counts as a pause for this instruction.
                    if (halt_req) begin
                        state_nxt  = ST_HALT;
                        pause_nxt  = 1'b0;
                        ring_clear = 1'b1;
                    end else if (pause_req || exec) begin
                        state_nxt  = ST_IDLE;
                        pause_nxt  = 1'b0;
                        ring_clear = 1'b1;
                    end
                end
            end
            ST_STEP: begin
                if (end_instr) begin
                    state_nxt  = halt_req ? ST_HALT : ST_IDLE;
                    ring_clear = 1'b1;
                end
            end
            default: ;  // ST_HALT: left only through reset
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pause_req <= 1'b0;
            pc        <= '0;
        end else begin
            state     <= state_nxt;
            pause_req <= pause_nxt;
            if (end_instr) pc <= branch_taken ? branch_target : pc_plus_one;
        end
    end

`ifdef PHASE_SEQ_ICOUNT_EN
    logic [31:0] icount_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         icount_q <= '0;
        else if (end_instr) icount_q <= icount_q + 32'd1;
    end

    assign instr_count = icount_q;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_phase_seq.sv
// ----------------------------------------------------------------------------
// tb_phase_seq
// Directed self-checking bench for phase_seq with default parameters
// (NPHASE=5, PC_W=16, MEM_PHASE=1). Inputs change and outputs are sampled
// 1 time unit after each rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_phase_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exec, step_mode, halt_req, mem_wait, branch_taken;
    logic [15:0] branch_target;
    logic [4:0]  phase;
    logic [15:0] pc, pc_plus_one;
    logic        running, halted;
    logic [31:0] instr_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    phase_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .exec          (exec),
        .step_mode     (step_mode),
        .halt_req      (halt_req),
        .mem_wait      (mem_wait),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .phase         (phase),
        .pc            (pc),
        .pc_plus_one   (pc_plus_one),
        .running       (running),
        .halted        (halted),
        .instr_count   (instr_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Expected retired-instruction count for the configured build.
    function automatic logic [31:0] exp_cnt(input int n);
`ifdef PHASE_SEQ_ICOUNT_EN
        return 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".phase"},   32'(phase), 32'd0);
        check({tag, ".pc"},      32'(pc), 32'd0);
        check({tag, ".running"}, 32'(running), 32'd0);
        check({tag, ".halted"},  32'(halted), 32'd0);
        check({tag, ".icount"},  instr_count, 32'd0);
    endtask

    // From phase 1, walk phases 2,4,8,16 checking each one.
    task automatic walk_to_last(input string tag);
        for (int k = 1; k < 5; k++) begin
            tick();
            check(tag, 32'(phase), 32'(1 << k));
        end
    endtask

    initial begin
        rst_n = 1'b0; exec = 1'b0; step_mode = 1'b0; halt_req = 1'b0;
        mem_wait = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
        #12;
        check_all_zero("reset");
        check("reset.pc1", 32'(pc_plus_one), 32'h0001);
        @(posedge clk); #1; rst_n = 1'b1;
        tick();

        // ---------------- run: two plain instructions ----------------
        exec = 1'b1;
        tick();
        exec = 1'b0;
        check("run.ph0", 32'(phase), 32'h01);
        check("run.running", 32'(running), 32'd1);
        walk_to_last("run.ph_i1");
        check("run.pc_before_end", 32'(pc), 32'd0);
        tick();
        check("run.wrap_ph0", 32'(phase), 32'h01);
        check("run.pc1", 32'(pc), 32'd1);
        walk_to_last("run.ph_i2");
        tick();
        check("run.pc2", 32'(pc), 32'd2);
        check("run.icount2", instr_count, exp_cnt(2));

        // ---------------- mem_wait stretches phase 1 ----------------
        tick();
        check("wait.ph1", 32'(phase), 32'h02);
        mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait.hold", 32'(phase), 32'h02);
        end
        mem_wait = 1'b0;
        tick();
        check("wait.release", 32'(phase), 32'h04);
        mem_wait = 1'b1;            // ignored outside MEM_PHASE
        tick();
        check("wait.ignored", 32'(phase), 32'h08);
        mem_wait = 1'b0;
        tick();
        check("wait.ph4", 32'(phase), 32'h10);
        check("wait.pc_held", 32'(pc), 32'd2);
        tick();
        check("wait.pc3", 32'(pc), 32'd3);

        // ---------------- branch and pc wrap ----------------
        walk_to_last("br.ph_i4");
        branch_taken = 1'b1; branch_target = 16'hFFFF;
        tick();
        branch_taken = 1'b0;
        check("br.pc_ffff", 32'(pc), 32'hFFFF);
        check("br.pc1_wrap", 32'(pc_plus_one), 32'h0000);
        walk_to_last("br.ph_i5");
        tick();
        check("br.pc_wrap0", 32'(pc), 32'h0000);
        walk_to_last("br.ph_i6");
        branch_taken = 1'b1; branch_target = 16'h0040;
        tick();
        branch_taken = 1'b0;
        check("br.pc_0040", 32'(pc), 32'h0040);
        check("br.icount6", instr_count, exp_cnt(6));

        // ---------------- pause mid-RUN ----------------
        tick();
        check("pause.ph1", 32'(phase), 32'h02);
        exec = 1'b1;
        tick();
        exec = 1'b0;
        check("pause.ph2_still_run", 32'(running), 32'd1);
        check("pause.ph2", 32'(phase), 32'h04);
        tick();
        tick();
        check("pause.ph4", 32'(phase), 32'h10);
        check("pause.ph4_run", 32'(running), 32'd1);
        tick();
        check("pause.idle_phase", 32'(phase), 32'h00);
        check("pause.idle_running", 32'(running), 32'd0);
        check("pause.idle_halted", 32'(halted), 32'd0);
        check("pause.pc", 32'(pc), 32'h0041);
        check("pause.icount7", instr_count, exp_cnt(7));
        tick();
        check("pause.stays_idle", 32'(phase), 32'h00);

        // ---------------- single step ----------------
        step_mode = 1'b1; exec = 1'b1;
        tick();
        step_mode = 1'b0; exec = 1'b0;
        check("step.ph0", 32'(phase), 32'h01);
        check("step.running", 32'(running), 32'd1);
        tick();
        exec = 1'b1;                // ignored in STEP
        tick();
        exec = 1'b0;
        halt_req = 1'b1;            // ignored away from instruction end
        check("step.ph2", 32'(phase), 32'h04);
        tick();
        halt_req = 1'b0;
        tick();
        check("step.ph4", 32'(phase), 32'h10);
        tick();
        check("step.idle_phase", 32'(phase), 32'h00);
        check("step.idle_running", 32'(running), 32'd0);
        check("step.not_halted", 32'(halted), 32'd0);
        check("step.pc", 32'(pc), 32'h0042);
        check("step.icount8", instr_count, exp_cnt(8));
        tick();
        check("step.stays_idle", 32'(phase), 32'h00);

        // ---------------- halt beats a pending pause ----------------
        exec = 1'b1;
        tick();
        exec = 1'b0;
        check("halt.run", 32'(running), 32'd1);
        tick();
        exec = 1'b1;
        tick();
        exec = 1'b0;
        tick();
        tick();
        check("halt.ph4", 32'(phase), 32'h10);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("halt.halted", 32'(halted), 32'd1);
        check("halt.running", 32'(running), 32'd0);
        check("halt.phase", 32'(phase), 32'h00);
        check("halt.pc", 32'(pc), 32'h0043);
        check("halt.icount9", instr_count, exp_cnt(9));
        exec = 1'b1;
        tick();
        exec = 1'b0;
        tick();
        check("halt.exec_ignored", 32'(halted), 32'd1);
        check("halt.exec_phase", 32'(phase), 32'h00);

        // ---------------- reset leaves HALT ----------------
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_halt");
        #1 rst_n = 1'b1;

        // ---------------- reset mid-phase[2] ----------------
        tick();
        exec = 1'b1;
        tick();
        exec = 1'b0;
        walk_to_last("rst.ph_i1");
        tick();
        check("rst.pc1", 32'(pc), 32'd1);
        tick();
        tick();
        check("rst.ph2", 32'(phase), 32'h04);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        #1 rst_n = 1'b1;
        tick();
        tick();
        check("rst.stays_idle", 32'(phase), 32'h00);
        check("rst.pc_stays", 32'(pc), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
